// File: rtl/fuse_ctrl_lc_prog_pkg.sv
// Shared types and constants for the LC program-request responder.
package fuse_ctrl_lc_prog_pkg;

  // lc_tx_t encoding of "escalation off"; every other value counts as escalation.
  localparam logic [3:0] LC_TX_OFF = 4'b1010;

  // Sparse state encoding: every pair of codes differs in at least 3 bits.
  // All-zero is ERROR, so a register that is stuck low lands in the terminal state.
  typedef enum logic [5:0] {
    IDLE  = 6'b000111,
    CHECK = 6'b011001,
    SCAN  = 6'b101010,
    WRITE = 6'b110100,
    WAIT  = 6'b101101,
    RESP  = 6'b110011,
    ERROR = 6'b000000
  } prog_state_e;

  // Number of programming words that make up the {count, state} image.
  function automatic int num_words(input int state_w, input int cnt_w, input int word_w);
    return (state_w + cnt_w) / word_w;
  endfunction

endpackage

// File: rtl/fuse_ctrl_lc_otp_program_rsp.sv
// OTP-side responder for the LC program request channel. It captures the
// requested {count, state} image, rejects it if any programmed bit would be
// cleared, and writes only the words that differ through the word-write port.
module fuse_ctrl_lc_otp_program_rsp
  import fuse_ctrl_lc_prog_pkg::*;
#(
  parameter int                STATE_W   = 320,
  parameter int                CNT_W     = 384,
  parameter int                WORD_W    = 16,
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               lc_otp_program_req_i,
  input  logic [STATE_W-1:0] lc_state_i,
  input  logic [CNT_W-1:0]   lc_count_i,
  input  logic [3:0]         lc_escalate_en_i,
  input  logic [STATE_W-1:0] cur_state_i,
  input  logic [CNT_W-1:0]   cur_count_i,
  output logic               wr_req_o,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic [WORD_W-1:0]  wr_data_o,
  input  logic               wr_gnt_i,
  input  logic               wr_done_i,
  input  logic               wr_err_i,
  output logic               lc_otp_program_ack_o,
  output logic               lc_otp_program_err_o,
  output logic               fsm_err_o
);

  localparam int NUM_WORDS  = num_words(STATE_W, CNT_W, WORD_W);
  localparam int IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int WORD_BYTES = WORD_W / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  prog_state_e state_q, state_d;

  logic [IDX_W-1:0] idx_q;
  logic             req_seen_q;
  logic             err_q;

  // Word 0 is the least significant word of the state; count words follow.
  logic [NUM_WORDS-1:0][WORD_W-1:0] new_words_q;
  logic [NUM_WORDS-1:0][WORD_W-1:0] cur_words_q;

  logic accept;
  logic illegal;
  logic word_diff;
  logic idx_last;
  logic escalate;

  assign escalate  = (lc_escalate_en_i != LC_TX_OFF);
  assign accept    = (state_q == IDLE) && lc_otp_program_req_i && !req_seen_q;
  assign illegal   = |(cur_words_q & ~new_words_q);
  assign word_diff = (new_words_q[idx_q] != cur_words_q[idx_q]);
  assign idx_last  = (idx_q == LAST_IDX);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; escalation overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CHECK;
      CHECK:   state_d = illegal ? RESP : SCAN;
      SCAN: begin
        if (word_diff)     state_d = WRITE;
        else if (idx_last) state_d = RESP;
      end
      WRITE:   if (wr_gnt_i) state_d = WAIT;
      WAIT: begin
        if (wr_done_i) begin
          if (wr_err_i || idx_last) state_d = RESP;
          else                      state_d = SCAN;
        end
      end
      RESP:    state_d = IDLE;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
    if (escalate) state_d = ERROR;
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    wr_req_o             = 1'b0;
    wr_addr_o            = '0;
    wr_data_o            = '0;
    lc_otp_program_ack_o = 1'b0;
    lc_otp_program_err_o = 1'b0;
    fsm_err_o            = 1'b0;
    case (state_q)
      WRITE: begin
        wr_req_o  = 1'b1;
        wr_addr_o = BASE_ADDR + ADDR_W'(idx_q) * ADDR_W'(WORD_BYTES);
        wr_data_o = new_words_q[idx_q];
      end
      RESP: begin
        lc_otp_program_ack_o = 1'b1;
        lc_otp_program_err_o = err_q;
      end
      IDLE, CHECK, SCAN, WAIT: ;
      default: fsm_err_o = 1'b1;
    endcase
  end

  // Word index, request-seen flag and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q      <= '0;
      req_seen_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (!lc_otp_program_req_i) begin
        req_seen_q <= 1'b0;
      end else if (accept) begin
        req_seen_q <= 1'b1;
      end
      case (state_q)
        CHECK: begin
          idx_q <= '0;
          if (illegal) err_q <= 1'b1;
        end
        SCAN: begin
          if (!word_diff && !idx_last) idx_q <= idx_q + 1'b1;
        end
        WAIT: begin
          if (wr_done_i) begin
            if (wr_err_i)       err_q <= 1'b1;
            else if (!idx_last) idx_q <= idx_q + 1'b1;
          end
        end
        RESP:    err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Snapshot of requested and current images taken when a request is accepted.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      new_words_q <= {lc_count_i, lc_state_i};
      cur_words_q <= {cur_count_i, cur_state_i};
    end
  end

endmodule

// File: tb/tb_fuse_ctrl_lc_otp_program_rsp.sv
// Self-checking bench for fuse_ctrl_lc_otp_program_rsp: directed table rows,
// randomized transactions against a word-level reference model, and
// hand-written reset / hold / escalation sequences.
module tb_fuse_ctrl_lc_otp_program_rsp;

  localparam int STATE_W  = 320;
  localparam int CNT_W    = 384;
  localparam int WORD_W   = 16;
  localparam int ADDR_W   = 12;
  localparam int NW       = (STATE_W + CNT_W) / WORD_W;
  localparam int SW       = STATE_W / WORD_W;
  localparam int MAX_CYC  = 800;
  localparam logic [3:0] ESC_OFF = 4'b1010;

  logic               clk_i;
  logic               rst_i;
  logic               lc_otp_program_req_i;
  logic [STATE_W-1:0] lc_state_i;
  logic [CNT_W-1:0]   lc_count_i;
  logic [3:0]         lc_escalate_en_i;
  logic [STATE_W-1:0] cur_state_i;
  logic [CNT_W-1:0]   cur_count_i;
  logic               wr_req_o;
  logic [ADDR_W-1:0]  wr_addr_o;
  logic [WORD_W-1:0]  wr_data_o;
  logic               wr_gnt_i;
  logic               wr_done_i;
  logic               wr_err_i;
  logic               lc_otp_program_ack_o;
  logic               lc_otp_program_err_o;
  logic               fsm_err_o;

  fuse_ctrl_lc_otp_program_rsp dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .lc_otp_program_req_i (lc_otp_program_req_i),
    .lc_state_i           (lc_state_i),
    .lc_count_i           (lc_count_i),
    .lc_escalate_en_i     (lc_escalate_en_i),
    .cur_state_i          (cur_state_i),
    .cur_count_i          (cur_count_i),
    .wr_req_o             (wr_req_o),
    .wr_addr_o            (wr_addr_o),
    .wr_data_o            (wr_data_o),
    .wr_gnt_i             (wr_gnt_i),
    .wr_done_i            (wr_done_i),
    .wr_err_i             (wr_err_i),
    .lc_otp_program_ack_o (lc_otp_program_ack_o),
    .lc_otp_program_err_o (lc_otp_program_err_o),
    .fsm_err_o            (fsm_err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checks = 0;
  int errors = 0;

  // Word images the bench drives, and what it expects to see written.
  logic [WORD_W-1:0] cur_w [NW];
  logic [WORD_W-1:0] new_w [NW];
  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [WORD_W-1:0] exp_data_q [$];
  logic [ADDR_W-1:0] log_addr_q [$];
  logic [WORD_W-1:0] log_data_q [$];
  int   wr_cnt   = 0;
  int   err_at   = 0;
  bit   hold_gnt = 1'b0;

  typedef struct {
    string             name;
    int                i0; logic [15:0] v0;
    int                i1; logic [15:0] v1;
    int                i2; logic [15:0] v2;
    int                ci; logic [15:0] cv;
    int                err_at;
    int                nwr;
    logic [11:0]       a0; logic [11:0] a1; logic [11:0] a2;
    logic              exp_err;
    int                exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic driveImages();
    for (int i = 0; i < NW; i++) begin
      if (i < SW) begin
        lc_state_i[i*WORD_W +: WORD_W]  = new_w[i];
        cur_state_i[i*WORD_W +: WORD_W] = cur_w[i];
      end else begin
        lc_count_i[(i-SW)*WORD_W +: WORD_W]  = new_w[i];
        cur_count_i[(i-SW)*WORD_W +: WORD_W] = cur_w[i];
      end
    end
  endtask

  task automatic clearImages();
    for (int i = 0; i < NW; i++) begin
      cur_w[i] = '0;
      new_w[i] = '0;
    end
  endtask

  // Reference model: rejection if any programmed bit would be cleared,
  // otherwise one write per differing word in ascending order, truncated at
  // the injected write error. Illegal requests ack in the 2nd cycle after the
  // request is taken; no-op requests spend one extra cycle per word scanned.
  task automatic buildModel(input int err_at_v, output logic exp_err, output int exp_lat);
    bit bad = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_err = 1'b0;
    exp_lat = 0;
    for (int i = 0; i < NW; i++)
      if ((cur_w[i] & ~new_w[i]) != 0) bad = 1'b1;
    if (bad) begin
      exp_err = 1'b1;
      exp_lat = 2;
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (new_w[i] != cur_w[i] && !exp_err) begin
          exp_addr_q.push_back(ADDR_W'(2 * i));
          exp_data_q.push_back(new_w[i]);
          if (exp_addr_q.size() == err_at_v) exp_err = 1'b1;
        end
      end
      if (exp_addr_q.size() == 0) exp_lat = 2 + NW;
    end
  endtask

  // Set up images and expectations from one table row.
  task automatic applyStimulus(input vec_t v);
    clearImages();
    if (v.ci >= 0) cur_w[v.ci] = v.cv;
    for (int i = 0; i < NW; i++) new_w[i] = cur_w[i];
    if (v.i0 >= 0) new_w[v.i0] = v.v0;
    if (v.i1 >= 0) new_w[v.i1] = v.v1;
    if (v.i2 >= 0) new_w[v.i2] = v.v2;
    exp_addr_q.delete();
    exp_data_q.delete();
    if (v.nwr > 0) begin exp_addr_q.push_back(v.a0); exp_data_q.push_back(v.v0); end
    if (v.nwr > 1) begin exp_addr_q.push_back(v.a1); exp_data_q.push_back(v.v1); end
    if (v.nwr > 2) begin exp_addr_q.push_back(v.a2); exp_data_q.push_back(v.v2); end
  endtask

  // Run one request to completion and compare the response and write log.
  task automatic runTxn(input string name, input int err_at_v, input logic exp_err,
                        input int exp_lat, input bit raise_req, input bit keep_req);
    int cyc = 0;
    int acks = 0;
    int ack_cyc = 0;
    logic got_err = 1'b0;
    log_addr_q.delete();
    log_data_q.delete();
    wr_cnt = 0;
    err_at = err_at_v;
    driveImages();
    if (raise_req) begin
      @(posedge clk_i); #1;
      lc_otp_program_req_i = 1'b1;
    end
    while (acks == 0 && cyc < MAX_CYC) begin
      @(posedge clk_i); #1;
      cyc++;
      if (lc_otp_program_ack_o) begin
        acks    = 1;
        got_err = lc_otp_program_err_o;
        ack_cyc = cyc;
      end
    end
    checkOutput({name, "_ack_seen"}, 64'(acks), 64'd1);
    if (acks == 1) begin
      checkOutput({name, "_err"}, 64'(got_err), 64'(exp_err));
      if (exp_lat > 0) checkOutput({name, "_latency"}, 64'(ack_cyc), 64'(exp_lat));
    end
    @(posedge clk_i); #1;
    checkOutput({name, "_ack_pulse"}, 64'(lc_otp_program_ack_o), 64'd0);
    if (!keep_req) lc_otp_program_req_i = 1'b0;
    checkOutput({name, "_nwrites"}, 64'(log_addr_q.size()), 64'(exp_addr_q.size()));
    for (int k = 0; k < log_addr_q.size() && k < exp_addr_q.size(); k++) begin
      checkOutput($sformatf("%s_addr%0d", name, k), 64'(log_addr_q[k]), 64'(exp_addr_q[k]));
      checkOutput($sformatf("%s_data%0d", name, k), 64'(log_data_q[k]), 64'(exp_data_q[k]));
    end
  endtask

  // Write-port responder: random grant and done delays, logs each granted
  // write and raises wr_err_i on the err_at-th completion.
  initial begin : responder
    logic [ADDR_W-1:0] a;
    logic [WORD_W-1:0] d;
    int n;
    wr_gnt_i  = 1'b0;
    wr_done_i = 1'b0;
    wr_err_i  = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (wr_req_o && !hold_gnt) begin
        a = wr_addr_o;
        d = wr_data_o;
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) begin
          @(posedge clk_i); #1;
          checkOutput("wr_stable", {wr_req_o, 4'h0, wr_addr_o, wr_data_o}, {1'b1, 4'h0, a, d});
        end
        wr_gnt_i = 1'b1;
        wr_cnt++;
        log_addr_q.push_back(a);
        log_data_q.push_back(d);
        @(posedge clk_i); #1;
        wr_gnt_i = 1'b0;
        checkOutput("wr_req_drop", 64'(wr_req_o), 64'd0);
        n = $urandom_range(0, 3);
        repeat (n) begin @(posedge clk_i); #1; end
        wr_done_i = 1'b1;
        wr_err_i  = (wr_cnt == err_at);
        @(posedge clk_i); #1;
        wr_done_i = 1'b0;
        wr_err_i  = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic exp_err;
    int   exp_lat;
    int   cnt_a;
    int   cnt_w;
    int   j;
    int   b;
    int   seen;

    vecs[0] = '{"two_words", 0, 16'h00A5, 3, 16'h1234, -1, 16'h0, -1, 16'h0, 0, 2,
                12'h000, 12'h006, 12'h000, 1'b0, 0};
    vecs[1] = '{"illegal_clear", 0, 16'h0000, -1, 16'h0, -1, 16'h0, 0, 16'h0001, 0, 0,
                12'h000, 12'h000, 12'h000, 1'b1, 2};
    vecs[2] = '{"wr_err_2nd", 1, 16'h0003, 7, 16'h0100, 30, 16'h8000, -1, 16'h0, 2, 2,
                12'h002, 12'h00E, 12'h03C, 1'b1, 0};
    vecs[3] = '{"noop", -1, 16'h0, -1, 16'h0, -1, 16'h0, -1, 16'h0, 0, 0,
                12'h000, 12'h000, 12'h000, 1'b0, 2 + NW};
    vecs[4] = '{"last_word", 43, 16'hFFFF, -1, 16'h0, -1, 16'h0, -1, 16'h0, 0, 1,
                12'h056, 12'h000, 12'h000, 1'b0, 0};
    vecs[5] = '{"state_cnt_edge", 19, 16'h0F0F, 20, 16'hF0F0, -1, 16'h0, -1, 16'h0, 0, 2,
                12'h026, 12'h028, 12'h000, 1'b0, 0};
    vecs[6] = '{"set_over_cur", 5, 16'h0013, -1, 16'h0, -1, 16'h0, 5, 16'h0011, 0, 1,
                12'h00A, 12'h000, 12'h000, 1'b0, 0};

    rst_i                = 1'b1;
    lc_otp_program_req_i = 1'b1;
    lc_escalate_en_i     = ESC_OFF;
    lc_state_i           = '0;
    lc_count_i           = '0;
    cur_state_i          = '0;
    cur_count_i          = '0;

    // Reset held three cycles with a request pending: outputs stay quiet.
    clearImages();
    new_w[2] = 16'h0042;
    driveImages();
    repeat (3) begin
      @(posedge clk_i); #1;
      checkOutput("reset_outs",
                  {wr_req_o, wr_addr_o, wr_data_o, lc_otp_program_ack_o, lc_otp_program_err_o, fsm_err_o},
                  64'd0);
    end
    rst_i = 1'b0;
    buildModel(0, exp_err, exp_lat);
    runTxn("after_reset", 0, exp_err, exp_lat, 1'b0, 1'b1);

    // Request held high after ack must not be served again.
    cnt_a = 0;
    cnt_w = 0;
    repeat (20) begin
      @(posedge clk_i); #1;
      if (lc_otp_program_ack_o) cnt_a++;
      if (wr_req_o) cnt_w++;
    end
    checkOutput("held_req_no_ack", 64'(cnt_a), 64'd0);
    checkOutput("held_req_no_write", 64'(cnt_w), 64'd0);
    lc_otp_program_req_i = 1'b0;

    // Directed table.
    for (int r = 0; r < 7; r++) begin
      applyStimulus(vecs[r]);
      runTxn(vecs[r].name, vecs[r].err_at, vecs[r].exp_err, vecs[r].exp_lat, 1'b1, 1'b0);
    end

    // Randomized transactions against the reference model.
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < NW; i++)
        cur_w[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      for (int i = 0; i < NW; i++) new_w[i] = cur_w[i];
      repeat ($urandom_range(0, 4)) begin
        j = $urandom_range(0, NW - 1);
        new_w[j] = new_w[j] | 16'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        j = $urandom_range(0, NW - 1);
        b = $urandom_range(0, WORD_W - 1);
        cur_w[j][b] = 1'b1;
        new_w[j][b] = 1'b0;
      end
      j = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      buildModel(j, exp_err, exp_lat);
      runTxn($sformatf("rand%0d", t), j, exp_err, exp_lat, 1'b1, 1'b0);
    end

    // Reset in the middle of a long scan: no ack afterwards.
    clearImages();
    driveImages();
    @(posedge clk_i); #1;
    lc_otp_program_req_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    lc_otp_program_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    cnt_a = 0;
    repeat (60) begin
      @(posedge clk_i); #1;
      if (lc_otp_program_ack_o) cnt_a++;
    end
    checkOutput("midreset_no_ack", 64'(cnt_a), 64'd0);

    // Escalation while a write request is pending.
    hold_gnt = 1'b1;
    clearImages();
    new_w[10] = 16'h0001;
    driveImages();
    @(posedge clk_i); #1;
    lc_otp_program_req_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 200 && seen == 0; c++) begin
      @(posedge clk_i); #1;
      if (wr_req_o) seen = 1;
    end
    checkOutput("esc_wr_req_seen", 64'(seen), 64'd1);
    lc_escalate_en_i = 4'b0101;
    @(posedge clk_i); #1;
    checkOutput("esc_wr_req_low", 64'(wr_req_o), 64'd0);
    checkOutput("esc_fsm_err", 64'(fsm_err_o), 64'd1);
    lc_escalate_en_i     = ESC_OFF;
    lc_otp_program_req_i = 1'b0;
    @(posedge clk_i); #1;
    lc_otp_program_req_i = 1'b1;
    cnt_a = 0;
    cnt_w = 0;
    repeat (20) begin
      @(posedge clk_i); #1;
      if (lc_otp_program_ack_o) cnt_a++;
      if (wr_req_o) cnt_w++;
    end
    checkOutput("esc_no_ack", 64'(cnt_a), 64'd0);
    checkOutput("esc_no_write", 64'(cnt_w), 64'd0);
    checkOutput("esc_sticky", 64'(fsm_err_o), 64'd1);
    lc_otp_program_req_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    hold_gnt = 1'b0;
    checkOutput("esc_cleared_by_reset", 64'(fsm_err_o), 64'd0);

    // Normal service resumes after reset.
    applyStimulus(vecs[0]);
    runTxn("post_esc", 0, 1'b0, 0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
